id_ex_alu_issue: RTL and testbench

ID/EX issue stage that produces the operand and control interface consumed by the EX-stage ALU: `Ctl[2:0]`, `shamt[4:0]`, `DataA[31:0]` and `DataB[31:0]`. Each cycle it can accept one decoded R-type instruction and translate its funct field into the ALU control code. It registers the operands and applies EX/MEM and MEM/WB forwarding. It also handles pipeline stall and flush, and keeps a saturating count of issued instructions.

---
 rtl/id_ex_alu_issue_pkg.sv | 46 ++++
 rtl/id_ex_alu_issue_fwd_mux.sv | 36 +++
 rtl/id_ex_alu_issue.sv | 115 +++++++++++
 tb/tb_id_ex_alu_issue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU control codes, R-type funct values and forwarding select type for the ID/EX issue stage.
package id_ex_alu_issue_pkg;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SRL = 3'b011;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EXMEM = 2'd1,
    MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic [2:0] ctl;
    logic       legal;
  } dec_t;

  // Unsupported functs fall back to ADD so the ALU sees a harmless code.
  function automatic dec_t decode(input logic [5:0] funct);
    dec_t d;
    d.ctl   = CTL_ADD;
    d.legal = 1'b1;
    case (funct)
      FUNCT_AND: d.ctl = CTL_AND;
      FUNCT_OR:  d.ctl = CTL_OR;
      FUNCT_ADD: d.ctl = CTL_ADD;
      FUNCT_SRL: d.ctl = CTL_SRL;
      FUNCT_SUB: d.ctl = CTL_SUB;
      FUNCT_SLT: d.ctl = CTL_SLT;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_fwd_mux.sv
// Per-operand forwarding mux: picks EX/MEM, then MEM/WB, then the registered value; r0 never forwards.
module fwd_mux
  import id_ex_alu_issue_pkg::*;
(
  input  logic [4:0]  addr,
  input  logic [31:0] reg_data,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        memwb_we,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] data
);

  fwd_sel_t sel;

  always_comb begin
    sel = NONE;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == addr)) begin
      sel = EXMEM;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == addr)) begin
      sel = MEMWB;
    end
  end

  always_comb begin
    data = reg_data;
    case (sel)
      EXMEM:   data = exmem_data;
      MEMWB:   data = memwb_data;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register for the ALU: funct decode, stall/flush capture, saturating issue count.
// Operand forwarding is built only when ID_EX_FWD_EN is defined; otherwise the hazard unit must stall.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  input  logic [5:0]       Funct,
  input  logic [4:0]       ShamtIn,
  input  logic [4:0]       RsAddr,
  input  logic [4:0]       RtAddr,
  input  logic [4:0]       RdAddr,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             ExMemRegWrite,
  input  logic             MemWbRegWrite,
  input  logic [4:0]       ExMemRd,
  input  logic [4:0]       MemWbRd,
  input  logic [31:0]      ExMemData,
  input  logic [31:0]      MemWbData,
  output logic             OutValid,
  output logic [2:0]       Ctl,
  output logic [4:0]       Shamt,
  output logic [31:0]      DataA,
  output logic [31:0]      DataB,
  output logic [4:0]       DstAddr,
  output logic             RegWrite,
  output logic             IllegalFunct,
  output logic [CNT_W-1:0] IssueCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dec_t        dec;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;

  assign dec = decode(Funct);

  // Flush only kills the control bits; operand registers are don't-care in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid     <= 1'b0;
      Ctl          <= CTL_ADD;
      Shamt        <= 5'd0;
      DstAddr      <= 5'd0;
      RegWrite     <= 1'b0;
      IllegalFunct <= 1'b0;
      IssueCount   <= '0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      rs_data_q    <= 32'd0;
      rt_data_q    <= 32'd0;
    end else if (Flush) begin
      OutValid     <= 1'b0;
      RegWrite     <= 1'b0;
      IllegalFunct <= 1'b0;
    end else if (!Stall) begin
      OutValid     <= InValid;
      Ctl          <= dec.ctl;
      Shamt        <= ShamtIn;
      DstAddr      <= RdAddr;
      RegWrite     <= InValid & dec.legal;
      IllegalFunct <= InValid & ~dec.legal;
      rs_q         <= RsAddr;
      rt_q         <= RtAddr;
      rs_data_q    <= RsData;
      rt_data_q    <= RtData;
      if (InValid && (IssueCount != '1)) begin
        IssueCount <= IssueCount + CNT_ONE;
      end
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_mux u_fwd_a (
    .addr       (rs_q),
    .reg_data   (rs_data_q),
    .exmem_we   (ExMemRegWrite),
    .exmem_rd   (ExMemRd),
    .exmem_data (ExMemData),
    .memwb_we   (MemWbRegWrite),
    .memwb_rd   (MemWbRd),
    .memwb_data (MemWbData),
    .data       (DataA)
  );

  fwd_mux u_fwd_b (
    .addr       (rt_q),
    .reg_data   (rt_data_q),
    .exmem_we   (ExMemRegWrite),
    .exmem_rd   (ExMemRd),
    .exmem_data (ExMemData),
    .memwb_we   (MemWbRegWrite),
    .memwb_rd   (MemWbRd),
    .memwb_data (MemWbData),
    .data       (DataB)
  );
`else
  logic unused_fwd;

  assign DataA = rs_data_q;
  assign DataB = rt_data_q;
  assign unused_fwd = ^{ExMemRegWrite, MemWbRegWrite, ExMemRd, MemWbRd,
                        ExMemData, MemWbData, rs_q, rt_q};
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: a spec-level model pushes expected EX state per edge, a monitor pops and compares.
module tb_id_ex_alu_issue;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             InValid = 1'b0;
  logic [5:0]       Funct = 6'd0;
  logic [4:0]       ShamtIn = 5'd0;
  logic [4:0]       RsAddr = 5'd0, RtAddr = 5'd0, RdAddr = 5'd0;
  logic [31:0]      RsData = 32'd0, RtData = 32'd0;
  logic             Stall = 1'b0, Flush = 1'b0;
  logic             ExMemRegWrite = 1'b0, MemWbRegWrite = 1'b0;
  logic [4:0]       ExMemRd = 5'd0, MemWbRd = 5'd0;
  logic [31:0]      ExMemData = 32'd0, MemWbData = 32'd0;
  logic             OutValid;
  logic [2:0]       Ctl;
  logic [4:0]       Shamt;
  logic [31:0]      DataA, DataB;
  logic [4:0]       DstAddr;
  logic             RegWrite;
  logic             IllegalFunct;
  logic [CNT_W-1:0] IssueCount;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Funct(Funct), .ShamtIn(ShamtIn),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr), .RsData(RsData), .RtData(RtData),
    .Stall(Stall), .Flush(Flush), .ExMemRegWrite(ExMemRegWrite), .MemWbRegWrite(MemWbRegWrite),
    .ExMemRd(ExMemRd), .MemWbRd(MemWbRd), .ExMemData(ExMemData), .MemWbData(MemWbData),
    .OutValid(OutValid), .Ctl(Ctl), .Shamt(Shamt), .DataA(DataA), .DataB(DataB),
    .DstAddr(DstAddr), .RegWrite(RegWrite), .IllegalFunct(IllegalFunct), .IssueCount(IssueCount)
  );

  typedef struct {
    bit          vld;
    int          ctl;
    int          shamt;
    int          dst;
    bit          regw;
    bit          ill;
    int          cnt;
    bit          dknown;
    logic [31:0] da;
    logic [31:0] db;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ctl_map[int];

  // Reference state of the EX stage, kept as plain integers.
  bit          m_vld = 0, m_regw = 0, m_ill = 0, m_dknown = 1;
  int          m_ctl = 2, m_shamt = 0, m_dst = 0, m_rs = 0, m_rt = 0, m_cnt = 0;
  logic [31:0] m_rsd = 0, m_rtd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input int r, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
    if (ExMemRegWrite && r != 0 && int'(ExMemRd) == r) return ExMemData;
    if (MemWbRegWrite && r != 0 && int'(MemWbRd) == r) return MemWbData;
`endif
    return v;
  endfunction

  function automatic void m_reset();
    m_vld = 0; m_regw = 0; m_ill = 0; m_dknown = 1;
    m_ctl = 2; m_shamt = 0; m_dst = 0; m_rs = 0; m_rt = 0; m_cnt = 0;
    m_rsd = 0; m_rtd = 0;
  endfunction

  always @(negedge rst_n) m_reset();

  initial begin
    exp_t e;
    bit   legal;
    ctl_map[6'b100100] = 0;
    ctl_map[6'b100101] = 1;
    ctl_map[6'b100000] = 2;
    ctl_map[6'b000010] = 3;
    ctl_map[6'b100010] = 6;
    ctl_map[6'b101010] = 7;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_reset();
      end else if (Flush) begin
        m_vld = 0; m_regw = 0; m_ill = 0; m_dknown = 0;
      end else if (!Stall) begin
        legal    = ctl_map.exists(int'(Funct));
        m_vld    = InValid;
        m_ctl    = legal ? ctl_map[int'(Funct)] : 2;
        m_shamt  = ShamtIn;
        m_dst    = RdAddr;
        m_rs     = RsAddr;
        m_rt     = RtAddr;
        m_rsd    = RsData;
        m_rtd    = RtData;
        m_regw   = InValid && legal;
        m_ill    = InValid && !legal;
        m_dknown = 1;
        if (InValid && m_cnt < CNT_MAX) m_cnt++;
      end
      e.vld = m_vld; e.ctl = m_ctl; e.shamt = m_shamt; e.dst = m_dst;
      e.regw = m_regw; e.ill = m_ill; e.cnt = m_cnt; e.dknown = m_dknown;
      e.da = fwd(m_rs, m_rsd);
      e.db = fwd(m_rt, m_rtd);
      sb.push_back(e);
    end
  end

  // Monitor: inputs only change on the falling edge, so posedge+2 sees the same forwarding inputs the model used.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("OutValid", 32'(OutValid), 32'(e.vld));
      chk("Ctl", 32'(Ctl), e.ctl);
      chk("Shamt", 32'(Shamt), e.shamt);
      chk("DstAddr", 32'(DstAddr), e.dst);
      chk("RegWrite", 32'(RegWrite), 32'(e.regw));
      chk("IllegalFunct", 32'(IllegalFunct), 32'(e.ill));
      chk("IssueCount", 32'(IssueCount), e.cnt);
      if (e.dknown) begin
        chk("DataA", DataA, e.da);
        chk("DataB", DataB, e.db);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [5:0] f, input logic [4:0] sh,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd);
    InValid = v; Funct = f; ShamtIn = sh;
    RsAddr = rs; RtAddr = rt; RdAddr = rd; RsData = rsd; RtData = rtd;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    ExMemRegWrite = ew; ExMemRd = erd; ExMemData = ed;
    MemWbRegWrite = mw; MemWbRd = mrd; MemWbData = md;
  endtask

  initial begin
    logic [5:0] fl [8];
    fl[0] = 6'b100100; fl[1] = 6'b100101; fl[2] = 6'b100000; fl[3] = 6'b000010;
    fl[4] = 6'b100010; fl[5] = 6'b101010; fl[6] = 6'b001000; fl[7] = 6'b111111;

    repeat (3) step();
    rst_n = 1'b1;

    // Basic decode of every supported funct plus an illegal one.
    step(); set_instr(1, 6'b100000, 0, 5, 6, 1, 32'd7, 32'd3);
    step(); set_instr(1, 6'b100010, 0, 1, 2, 3, 32'd10, 32'd4);
    step(); set_instr(1, 6'b100100, 0, 1, 2, 3, 32'hF0, 32'h3C);
    step(); set_instr(1, 6'b100101, 0, 1, 2, 3, 32'hF0, 32'h3C);
    step(); set_instr(1, 6'b101010, 0, 1, 2, 4, 32'd1, 32'd2);
    step(); set_instr(1, 6'b000010, 4, 0, 2, 4, 32'd0, 32'h80);
    step(); set_instr(1, 6'b001000, 0, 7, 8, 9, 32'd5, 32'd6);

    // Forwarding priority and the r0 exclusion.
    step(); set_instr(1, 6'b100000, 0, 5, 6, 2, 32'd7, 32'd3);
    set_fwd(1, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    step(); set_fwd(0, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    step(); set_instr(1, 6'b100000, 0, 0, 0, 2, 32'd9, 32'd8);
    set_fwd(1, 0, 32'hAAAA, 1, 0, 32'hBBBB);
    step(); set_fwd(0, 0, 0, 0, 0, 0);

    // Three-cycle stall with a new instruction waiting; a MEM/WB write to Rt lands mid-stall.
    step(); set_instr(1, 6'b100000, 0, 3, 4, 5, 32'd11, 32'd22);
    step(); Stall = 1; set_instr(1, 6'b100010, 1, 9, 10, 11, 32'd99, 32'd98);
    step(); set_fwd(0, 0, 0, 1, 4, 32'h1234);
    step();
    step(); Stall = 0; set_fwd(0, 0, 0, 0, 0, 0);

    // Stall and flush together kill a valid ADD without counting it.
    step(); Stall = 1; Flush = 1; set_instr(1, 6'b100000, 0, 1, 2, 3, 32'd1, 32'd2);
    step(); Stall = 0; Flush = 0; set_instr(0, 6'b100000, 0, 1, 2, 3, 32'd1, 32'd2);

    // Twenty valid issues drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      step(); set_instr(1, fl[$urandom_range(0, 5)], 5'($urandom), 5'($urandom),
                        5'($urandom), 5'($urandom), $urandom, $urandom);
    end
    step(); set_instr(0, 6'b100000, 0, 0, 0, 0, 0, 0);
    chk("IssueCount_saturated", 32'(IssueCount), 32'd15);

    // Randomized traffic with small register numbers so forwarding hits are frequent.
    for (int i = 0; i < 300; i++) begin
      step();
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      set_instr(1'($urandom), fl[$urandom_range(0, 7)], 5'($urandom),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                $urandom, $urandom);
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset in the middle of a stall clears the stage without a clock edge.
    step(); Stall = 1; set_fwd(0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_OutValid", 32'(OutValid), 32'd0);
    chk("async_RegWrite", 32'(RegWrite), 32'd0);
    chk("async_IllegalFunct", 32'(IllegalFunct), 32'd0);
    chk("async_Ctl", 32'(Ctl), 32'd2);
    chk("async_Shamt", 32'(Shamt), 32'd0);
    chk("async_DstAddr", 32'(DstAddr), 32'd0);
    chk("async_IssueCount", 32'(IssueCount), 32'd0);
    chk("async_DataA", DataA, 32'd0);
    chk("async_DataB", DataB, 32'd0);
    step(); Stall = 0;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); set_instr(1, fl[$urandom_range(0, 7)], 5'($urandom), 5'($urandom),
                        5'($urandom), 5'($urandom), $urandom, $urandom);
    end
    step(); set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
